sync_fifo_ctrl: RTL and testbench



---
 rtl/sync_fifo_ctrl_if.sv | 35 +++
 rtl/sync_fifo_ctrl.sv | 119 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
`timescale 1ns/1ps
// Producer, consumer and RAM-side signals of the FWFT FIFO controller.
// The slave modport is the controller's view; the master modport is its environment.
interface sync_fifo_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 13
);
    logic              iflush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] idata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] odata;
    logic              ram_en_wr;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W+1:0] level;
    logic              full;
    logic              empty;

    modport slave (
        input  iflush, in_valid, idata, out_ready, ram_rdata,
        output in_ready, out_valid, odata, ram_en_wr, ram_wr_addr, ram_wdata,
               ram_rd_addr, level, full, empty
    );

    modport master (
        output iflush, in_valid, idata, out_ready, ram_rdata,
        input  in_ready, out_valid, odata, ram_en_wr, ram_wr_addr, ram_wdata,
               ram_rd_addr, level, full, empty
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
`timescale 1ns/1ps
// First-word-fall-through FIFO controller in front of a registered-read dual-port RAM.
// A 2-entry skid buffer hides the RAM read latency so the consumer can take one word per cycle.
module sync_fifo_ctrl #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 13
) (
    input  logic            iclk,
    input  logic            irst,
    sync_fifo_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic              r_inflight;
    logic [1:0]        r_skid_cnt;
    logic [DATA_W-1:0] r_skid0;
    logic [DATA_W-1:0] r_skid1;

    logic              w_full;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_fetch;
    logic [2:0]        w_occ;
    logic [ADDR_W+1:0] w_level;

    assign w_full      = (r_ram_cnt == L_DEPTH);
    assign w_out_valid = (r_skid_cnt != 2'd0);
    assign w_push      = bus.in_valid & ~w_full & ~bus.iflush & ~irst;
    assign w_pop       = w_out_valid & bus.out_ready & ~bus.iflush;

    // Words already owed to the skid buffer after this edge; a fetch needs room for one more.
    assign w_occ   = {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_fetch = (r_ram_cnt != '0) & (w_occ < 3'd2) & ~bus.iflush;

    assign w_level = {1'b0, r_ram_cnt}
                   + {{ADDR_W{1'b0}}, r_skid_cnt}
                   + {{(ADDR_W+1){1'b0}}, r_inflight};

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end else if (bus.iflush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_inflight <= w_fetch;
            case ({w_push, w_fetch})
                2'b10:   r_ram_cnt <= r_ram_cnt + (ADDR_W+1)'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - (ADDR_W+1)'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    // Skid buffer: r_skid0 is the head; the RAM word returned for last cycle's fetch lands here.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_skid_cnt <= 2'd0;
            r_skid0    <= '0;
            r_skid1    <= '0;
        end else if (bus.iflush) begin
            r_skid_cnt <= 2'd0;
            r_skid0    <= '0;
            r_skid1    <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_skid_cnt == 2'd0) begin
                        r_skid0 <= bus.ram_rdata;
                    end else begin
                        r_skid1 <= bus.ram_rdata;
                    end
                    r_skid_cnt <= r_skid_cnt + 2'd1;
                end
                2'b01: begin
                    r_skid0    <= r_skid1;
                    r_skid_cnt <= r_skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_skid_cnt == 2'd1) begin
                        r_skid0 <= bus.ram_rdata;
                    end else begin
                        r_skid0 <= r_skid1;
                        r_skid1 <= bus.ram_rdata;
                    end
                end
                default: begin
                    r_skid_cnt <= r_skid_cnt;
                end
            endcase
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.full        = w_full;
    assign bus.out_valid   = w_out_valid;
    assign bus.odata       = r_skid0;
    assign bus.ram_en_wr   = w_push;
    assign bus.ram_wr_addr = r_wr_ptr;
    assign bus.ram_wdata   = bus.idata;
    assign bus.ram_rd_addr = r_rd_ptr;
    assign bus.level       = w_level;
    assign bus.empty       = (w_level == '0);
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
`timescale 1ns/1ps
// Bench for sync_fifo_ctrl with ADDR_W=4: RAM stub, word-timestamp reference model, per-cycle compare.
module tb_sync_fifo_ctrl;
    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    sync_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sync_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus.slave)
    );

    // Registered-read, read-before-write RAM.
    logic [DW-1:0] mem [0:DEPTH-1];
    always_ff @(posedge iclk) begin
        if (bus.ram_en_wr) mem[bus.ram_wr_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_rd_addr];
    end

    // Reference model: every word gets a sequence number; the FIFO state is just three
    // counters (pushed, fetched from RAM, popped) plus the edge at which each word was fetched.
    int n_push = 0, n_fetch = 0, n_pop = 0, m_wp = 0, ec = 0;
    logic [DW-1:0] words   [0:8191];
    int            fetch_e [0:8191];
    int  checks = 0, errors = 0;
    bit  chk_on = 1'b0;
    int  dut_pops = 0;

    function automatic logic [12:0] ix(input int n);
        return 13'(n);
    endfunction

    function automatic bit m_ov();
        return (n_pop < n_fetch) && (fetch_e[ix(n_pop)] < ec);
    endfunction

    function automatic bit m_ir();
        return (n_push - n_fetch) != DEPTH;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        bit pop, push, fetch;
        forever begin
            @(posedge iclk or posedge irst);
            if (irst) begin
                n_pop = n_push; n_fetch = n_push; m_wp = 0;
            end else begin
                pop  = m_ov() && bus.out_ready && !bus.iflush;
                push = m_ir() && bus.in_valid && !bus.iflush;
                if (bus.iflush) begin
                    n_pop = n_push; n_fetch = n_push; m_wp = 0;
                end else begin
                    if (pop) n_pop++;
                    // A word is fetchable once pushed on an earlier edge and at most one
                    // other fetched word is still waiting for the consumer.
                    fetch = (n_fetch < n_push) && (n_fetch - n_pop < 2);
                    if (fetch) begin
                        fetch_e[ix(n_fetch)] = ec + 1;
                        n_fetch++;
                    end
                    if (push) begin
                        words[ix(n_push)] = bus.idata;
                        n_push++;
                        m_wp = (m_wp + 1) % DEPTH;
                    end
                end
                ec++;
            end
        end
    end

    initial begin
        bit expen;
        forever begin
            @(negedge iclk);
            if (chk_on) begin
                chk("in_ready",  32'(bus.in_ready),  32'(m_ir()));
                chk("full",      32'(bus.full),      32'(!m_ir()));
                chk("level",     32'(bus.level),     n_push - n_pop);
                chk("empty",     32'(bus.empty),     32'(n_push == n_pop));
                chk("out_valid", 32'(bus.out_valid), 32'(m_ov()));
                if (m_ov()) chk("odata", 32'(bus.odata), 32'(words[ix(n_pop)]));
                expen = bus.in_valid && m_ir() && !bus.iflush && !irst;
                chk("ram_en_wr", 32'(bus.ram_en_wr), 32'(expen));
                if (expen) begin
                    chk("ram_wr_addr", 32'(bus.ram_wr_addr), m_wp);
                    chk("ram_wdata",   32'(bus.ram_wdata),   32'(bus.idata));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge iclk);
            if (!irst && bus.out_valid && bus.out_ready && !bus.iflush) dut_pops++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge iclk);
        #1;
    endtask

    task automatic sync_reset();
        irst = 1'b1;
        cyc();
        irst = 1'b0;
    endtask

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.idata     = DW'($urandom);
            cyc();
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (bus.level != '0 && n < 100) begin
            cyc();
            n++;
        end
        chk(nm, 32'(bus.level), 32'd0);
    endtask

    initial begin
        int acc, cnt;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.iflush = 1'b0; bus.idata = '0;
        irst = 1'b1;
        repeat (3) @(posedge iclk);
        #1;
        irst = 1'b0;
        chk_on = 1'b1;
        chk("rst_level",     32'(bus.level),       32'd0);
        chk("rst_empty",     32'(bus.empty),       32'd1);
        chk("rst_in_ready",  32'(bus.in_ready),    32'd1);
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_odata",     32'(bus.odata),       32'd0);
        chk("rst_rd_addr",   32'(bus.ram_rd_addr), 32'd0);

        // single word: push edge 0, visible after edge 2, popped at edge 3
        bus.in_valid = 1'b1; bus.idata = 24'h000001; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("t1_not_yet", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_odata",     32'(bus.odata),     32'h1);
        chk("t1_level",     32'(bus.level),     32'd1);
        cyc();
        chk("t1_level_pop", 32'(bus.level), 32'd0);
        chk("t1_empty",     32'(bus.empty), 32'd1);

        // continuous stream, one word per cycle
        dut_pops = 0;
        for (int k = 0; k < 64; k++) begin
            bus.in_valid = 1'b1;
            bus.idata    = DW'(32'h100 + k);
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc(); cyc();
        chk("t2_pops_63", 32'(dut_pops), 32'd63);
        cyc();
        chk("t2_pops_64", 32'(dut_pops), 32'd64);
        chk("t2_level",   32'(bus.level), 32'd0);

        // fill to the brim with the consumer stalled
        sync_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.in_ready) break;
            bus.idata = DW'($urandom);
            acc++;
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("t3_accepted", 32'(acc),          32'd18);
        chk("t3_full",     32'(bus.full),     32'd1);
        chk("t3_level",    32'(bus.level),    32'd18);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t3_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.idata = 24'hABCDEF;
        #1;
        chk("t3_wr_en",   32'(bus.ram_en_wr),   32'd1);
        chk("t3_wr_addr", 32'(bus.ram_wr_addr), 32'd2);
        cyc();
        drain("t3_drain");

        // random traffic
        acc = 0; cnt = 0;
        while (acc < 5000 && cnt < 60000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.idata     = DW'($urandom);
            if (bus.in_valid && bus.in_ready) acc++;
            cyc();
            cnt++;
        end
        chk("t4_words", 32'(acc), 32'd5000);
        drain("t4_drain");

        // flush with a read in flight and a push/pop request in the same cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.idata    = DW'(32'h500 + i);
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        bus.out_ready = 1'b1;
        cyc();
        bus.iflush = 1'b1; bus.in_valid = 1'b1; bus.idata = 24'h000055;
        #1;
        chk("t5_no_write", 32'(bus.ram_en_wr), 32'd0);
        cyc();
        bus.iflush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("t5_level",     32'(bus.level),     32'd0);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1; bus.idata = 24'h000777; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("t5_not_yet", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("t5_out_valid_word", 32'(bus.out_valid), 32'd1);
        chk("t5_odata",          32'(bus.odata),     32'h777);
        chk("t5_level_one",      32'(bus.level),     32'd1);
        cyc();
        chk("t5_level_done", 32'(bus.level), 32'd0);

        // asynchronous reset between edges
        rand_traffic(100);
        bus.in_valid = 1'b1;
        @(posedge iclk);
        #3;
        irst = 1'b1;
        #1;
        chk("t6_level",     32'(bus.level),       32'd0);
        chk("t6_out_valid", 32'(bus.out_valid),   32'd0);
        chk("t6_empty",     32'(bus.empty),       32'd1);
        chk("t6_full",      32'(bus.full),        32'd0);
        chk("t6_in_ready",  32'(bus.in_ready),    32'd1);
        chk("t6_wr_en",     32'(bus.ram_en_wr),   32'd0);
        chk("t6_wr_addr",   32'(bus.ram_wr_addr), 32'd0);
        chk("t6_rd_addr",   32'(bus.ram_rd_addr), 32'd0);
        chk("t6_odata",     32'(bus.odata),       32'd0);
        repeat (2) @(posedge iclk);
        #4;
        irst = 1'b0;
        cyc();
        rand_traffic(200);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
